// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch/execute sequencer for a single-issue core. It owns the program
// counter and the instruction register. It requests one 32-bit word from
// instruction memory, then holds it in the instruction register while the
// control unit executes it. When execution ends it selects the next PC from
// the control word.
//
// Ports
//   clock        single clock, all state updates on posedge
//   reset        asynchronous, active-low reset
//   imem_req     instruction-memory read request (held until ack)
//   imem_addr    byte address of the requested word (= pc)
//   imem_ack     read-data valid strobe, honoured only while requesting
//   imem_rdata   instruction word, valid when imem_ack = 1
//   instruction  instruction register, feeds control-unit decode
//   instr_valid  instruction register holds a word being executed
//   ps           PC select: 00 hold/halt, 01 pc+4, 10 reg_a, 11 pc+(k<<2)
//   k            branch offset in words, two's complement
//   reg_a        register-file A output, jump target for ps = 10
//   ns           1 = current instruction needs another execute cycle
//   pc           current program counter
//   pc_plus4     pc + 4, link value for BL
//   halted       fetch stopped by ps = 00, left only through reset
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic [1:0]  ps,
    input  logic [63:0] k,
    input  logic [63:0] reg_a,
    input  logic        ns,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        halted_q;

    // PC chosen by the control word when the current instruction retires.
    // All additions wrap modulo 2^64 and the low pc bits pass through, so a
    // misaligned target is fetched as-is.
    logic [63:0] pc_d;

    // NOTE: every signal assigned in always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        pc_d = pc_q;
        case (ps)
            2'b01:   pc_d = pc_q + 64'd4;
            2'b10:   pc_d = reg_a;
            2'b11:   pc_d = pc_q + {k[61:0], 2'b00};
            default: pc_d = pc_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            // The request is registered, so it is low for the whole reset
            // and rises on the first edge after release. Gating ack
            // acceptance on it drops any ack that belongs to a request
            // abandoned by reset.
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q && imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= EXEC;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end

                EXEC: begin
                    // ns = 1 keeps the instruction in execute and overrides ps.
                    if (!ns) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        if (ps == 2'b00) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            req_q    <= 1'b1;
                            state_q  <= FETCH;
                        end
                    end
                end

                HALT: begin
                    state_q <= HALT;
                end

                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 64'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed and randomized bench for instruction_fetch. The reference model
// works at transaction level: each fetch is "wait N cycles, deliver a word",
// each execute is "spend N extra cycles, then retire with ps/k/reg_a", and
// the expected PC is plain 64-bit arithmetic on those operands.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [1:0]  ps;
    logic [63:0] k;
    logic [63:0] reg_a;
    logic        ns;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .ps          (ps),
        .k           (k),
        .reg_a       (reg_a),
        .ns          (ns),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one full cycle; returns at the next negedge, away from the
    // active edge, where outputs are sampled and inputs are changed.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reset asserted mid-cycle. Outputs must react before any clock edge;
    // an ack held through reset and release must not be captured.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_pc",     pc,                  RESET_PC);
        check("rst_instr",  64'(instruction),    64'h0);
        check("rst_valid",  64'(instr_valid),    64'h0);
        check("rst_halted", 64'(halted),         64'h0);
        check("rst_req",    64'(imem_req),       64'h0);
        @(negedge clock);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        tick();
        check("rst_hold_req",   64'(imem_req),    64'h0);
        check("rst_hold_instr", 64'(instruction), 64'h0);
        reset = 1'b1;
        tick();
        check("rel_req",   64'(imem_req),    64'h1);
        check("rel_valid", 64'(instr_valid), 64'h0);
        check("rel_instr", 64'(instruction), 64'h0);
        check("rel_pc",    pc,               RESET_PC);
        imem_ack = 1'b0;
        m_pc    = RESET_PC;
        m_instr = 32'h0;
    endtask

    // Memory answers after `lat` idle request cycles with `word`.
    task automatic fetch(input int lat, input logic [31:0] word);
        for (int i = 0; i < lat; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            check("fetch_req_wait",   64'(imem_req),    64'h1);
            check("fetch_addr_wait",  imem_addr,        m_pc);
            check("fetch_valid_wait", 64'(instr_valid), 64'h0);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        check("fetch_req",    64'(imem_req), 64'h1);
        check("fetch_addr",   imem_addr,     m_pc);
        check("fetch_halted", 64'(halted),   64'h0);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        check("exec_instr", 64'(instruction), 64'(m_instr));
        check("exec_valid", 64'(instr_valid), 64'h1);
        check("exec_req",   64'(imem_req),    64'h0);
        check("exec_pc",    pc,               m_pc);
    endtask

    // Instruction stays `extra` cycles with ns=1, then retires with sel.
    task automatic exec(input int extra, input logic [1:0] sel,
                        input logic [63:0] kk, input logic [63:0] ra);
        for (int i = 0; i < extra; i++) begin
            ns         = 1'b1;
            ps         = 2'($urandom_range(0, 3));
            k          = {$urandom, $urandom};
            reg_a      = {$urandom, $urandom};
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            tick();
            check("multi_valid", 64'(instr_valid), 64'h1);
            check("multi_instr", 64'(instruction), 64'(m_instr));
            check("multi_pc",    pc,               m_pc);
            check("multi_req",   64'(imem_req),    64'h0);
        end
        ns       = 1'b0;
        ps       = sel;
        k        = kk;
        reg_a    = ra;
        imem_ack = 1'b0;
        check("link_pc_plus4", pc_plus4, m_pc + 64'd4);
        tick();
        ps = 2'b00;
        case (sel)
            2'b01:   m_pc = m_pc + 64'd4;
            2'b10:   m_pc = ra;
            2'b11:   m_pc = m_pc + kk * 64'd4;
            default: m_pc = m_pc;
        endcase
        check("retire_pc",    pc,               m_pc);
        check("retire_valid", 64'(instr_valid), 64'h0);
        if (sel == 2'b00) begin
            check("halt_halted", 64'(halted),   64'h1);
            check("halt_req",    64'(imem_req), 64'h0);
        end else begin
            check("next_halted", 64'(halted),   64'h0);
            check("next_req",    64'(imem_req), 64'h1);
            check("next_addr",   imem_addr,     m_pc);
        end
    endtask

    initial begin
        int          lat;
        int          extra;
        int          s;
        logic [1:0]  sel;
        logic [63:0] kk;

        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        ps         = 2'b00;
        k          = 64'h0;
        reg_a      = 64'h0;
        ns         = 1'b0;
        m_pc       = RESET_PC;
        m_instr    = 32'h0;

        @(negedge clock);
        do_reset();

        // First fetch after reset: address 0 presented for three cycles.
        fetch(2, 32'h8B0203E1);
        exec(0, 2'b01, 64'h0, 64'h0);

        // Straight-line run with single-cycle ack: pc 4, 8, C.
        fetch(0, 32'h91000421);
        exec(0, 2'b01, 64'h0, 64'h0);
        fetch(0, 32'hD503201F);
        exec(0, 2'b01, 64'h0, 64'h0);
        check("seq_pc_c", pc, 64'hC);

        // Branches and jumps around pc = 0x10.
        fetch(0, 32'h14000001);
        exec(0, 2'b10, 64'h0, 64'h10);
        fetch(1, 32'h17FFFFFE);
        exec(0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        check("br_back", pc, 64'h08);
        fetch(0, 32'hD61F0000);
        exec(0, 2'b10, 64'h0, 64'h10);
        fetch(0, 32'h14000003);
        exec(0, 2'b11, 64'h3, 64'h0);
        check("br_fwd", pc, 64'h1C);
        fetch(0, 32'hD61F0000);
        exec(0, 2'b10, 64'h0, 64'h10);
        fetch(0, 32'hD61F0020);
        exec(0, 2'b10, 64'h0, 64'h400);
        check("jmp_400", pc, 64'h400);

        // Two-cycle instruction: valid held two cycles, pc moves once.
        fetch(0, 32'hF2A00020);
        exec(1, 2'b01, 64'h0, 64'h0);
        check("movk_pc", pc, 64'h404);

        // Wrap at 2^64 and misaligned targets pass through.
        fetch(0, 32'hD61F0040);
        exec(0, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0, 32'h0000_0001);
        exec(0, 2'b01, 64'h0, 64'h0);
        check("wrap_pc", pc, 64'h0);
        fetch(0, 32'h0000_0002);
        exec(0, 2'b10, 64'h0, 64'h401);
        fetch(0, 32'h0000_0003);
        exec(0, 2'b01, 64'h0, 64'h0);
        check("misalign_pc", pc, 64'h405);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            lat   = $urandom_range(0, 3);
            extra = $urandom_range(0, 2);
            sel   = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                s  = $urandom_range(0, 40);
                s  = s - 20;
                kk = {{32{s[31]}}, s};
            end else begin
                kk = {$urandom, $urandom};
            end
            fetch(lat, $urandom);
            exec(extra, sel, kk, {$urandom, $urandom});
        end

        // Reset while a fetch is pending; late ack must be dropped.
        check("pend_req", 64'(imem_req), 64'h1);
        imem_ack = 1'b0;
        tick();
        do_reset();
        fetch(1, 32'hAAAA_5555);

        // Halt: no requests despite ack pulses, left only through reset.
        exec(0, 2'b00, 64'h0, 64'h0);
        for (int i = 0; i < 6; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            ns         = 1'($urandom_range(0, 1));
            ps         = 2'($urandom_range(0, 3));
            tick();
            check("halt_stay",  64'(halted),      64'h1);
            check("halt_noreq", 64'(imem_req),    64'h0);
            check("halt_novld", 64'(instr_valid), 64'h0);
            check("halt_pc",    pc,               m_pc);
        end
        imem_ack = 1'b0;
        ns       = 1'b0;
        ps       = 2'b00;
        do_reset();
        fetch(0, 32'h1234_5678);
        exec(0, 2'b01, 64'h0, 64'h0);
        check("restart_pc", pc, RESET_PC + 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
